// File: rtl/instr_loader.sv
// Serial program loader: assembles a host byte stream into 18-bit instruction
// words, writes them to instruction memory and holds the CPU until the image verifies.
//
// state  | meaning
// IDLE   | after reset, waiting for start, CPU held
// HDR_HI | expecting count[9:8] byte
// HDR_LO | expecting count[7:0] byte
// B0     | expecting instr[17:16] byte
// B1     | expecting instr[15:8] byte
// B2     | expecting instr[7:0] byte
// WRITE  | one-cycle memory write of the assembled word
// CHK    | expecting checksum byte
// DONE   | image verified, CPU released
// ERR    | format, checksum or timeout failure, CPU held
module instr_loader #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_HDR_HI = 4'd1;
  localparam logic [3:0] S_HDR_LO = 4'd2;
  localparam logic [3:0] S_B0     = 4'd3;
  localparam logic [3:0] S_B1     = 4'd4;
  localparam logic [3:0] S_B2     = 4'd5;
  localparam logic [3:0] S_WRITE  = 4'd6;
  localparam logic [3:0] S_CHK    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_ERR    = 4'd9;

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [3:0]        state;
  logic [9:0]        count;
  logic [9:0]        idx;
  logic [7:0]        xsum;
  logic [TMO_W-1:0]  tmo;
  logic [DATA_W-1:0] word;
  logic              xfer;

  // All outputs come from registers only, so in_ready never depends on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_HDR_HI, S_HDR_LO, S_B0, S_B1, S_B2, S_CHK: in_ready = 1'b1;
      default:                                     in_ready = 1'b0;
    endcase
  end

  assign xfer       = in_valid & in_ready;
  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = ADDR_W'(idx);
  assign imem_wdata = word;
  assign cpu_hold   = (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      idx   <= '0;
      xsum  <= '0;
      tmo   <= '0;
      word  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_HDR_HI;
            idx   <= '0;
            xsum  <= '0;
            tmo   <= '0;
          end
        end
        S_WRITE: begin
          // index stops at the frame count, not at the memory size
          if (idx == count) begin
            state <= S_CHK;
          end else begin
            idx   <= idx + 10'd1;
            state <= S_B0;
          end
        end
        S_HDR_HI, S_HDR_LO, S_B0, S_B1, S_B2, S_CHK: begin
          if (xfer) begin
            tmo  <= '0;
            xsum <= xsum ^ in_data;
            case (state)
              S_HDR_HI: begin
                if (in_data[7:2] != 6'd0) begin
                  state <= S_ERR;
                end else begin
                  count[9:8] <= in_data[1:0];
                  state      <= S_HDR_LO;
                end
              end
              S_HDR_LO: begin
                count[7:0] <= in_data;
                state      <= S_B0;
              end
              S_B0: begin
                if (in_data[7:2] != 6'd0) begin
                  state <= S_ERR;
                end else begin
                  word[17:16] <= in_data[1:0];
                  state       <= S_B1;
                end
              end
              S_B1: begin
                word[15:8] <= in_data;
                state      <= S_B2;
              end
              S_B2: begin
                word[7:0] <= in_data;
                state     <= S_WRITE;
              end
              default: state <= (in_data == xsum) ? S_DONE : S_ERR;
            endcase
          end else begin
            tmo <= tmo + 1'b1;
            if (tmo == TMO_W'(TIMEOUT - 1)) state <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of single-word frames plus
// hand-written timing, timeout, backpressure, reset and full-image sequences.
module tb_instr_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int nwrites = 0;

  logic [27:0] exp_q[$];
  logic [17:0] img[1024];

  typedef struct {
    logic [47:0] bytes;
    int          nb;
    logic        we;
    logic [17:0] data;
    logic        dn;
    logic        er;
  } vec_t;
  vec_t vt[7];

  instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, writes scoreboarded.
  task automatic tick();
    logic [27:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (imem_we) begin
      nwrites++;
      check("ready_in_write", in_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[27:18]);
        check("wr_data", imem_wdata, e[17:0]);
      end
    end
  endtask

  function automatic int gap(input int m);
    return (m == 0) ? 0 : int'($urandom_range(m, 0));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int g);
    logic acc;
    in_valid = 1'b0;
    repeat (g) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 64; n++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL byte_accept: byte 0x%0h not accepted within 64 cycles, expected acceptance", b);
  endtask

  task automatic put(input logic [7:0] b, input int max_gap, inout logic [7:0] x);
    x = x ^ b;
    send_byte(b, gap(max_gap));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends header and the first n_send words of img; checksum only for a full frame.
  task automatic send_frame(input int nwords, input int max_gap, input int start_at, input int n_send);
    logic [7:0] x;
    logic [9:0] c;
    x = 8'h00;
    c = 10'(nwords - 1);
    put({6'd0, c[9:8]}, max_gap, x);
    put(c[7:0], max_gap, x);
    for (int i = 0; i < n_send; i++) begin
      exp_q.push_back({10'(i), img[i]});
      if (i == start_at) pulse_start();
      put({6'd0, img[i][17:16]}, max_gap, x);
      put(img[i][15:8], max_gap, x);
      put(img[i][7:0], max_gap, x);
    end
    if (n_send == nwords) send_byte(x, gap(max_gap));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    logic [47:0] sh;
    int t0;
    int n;
    int w0;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check("idle_hold", cpu_hold, 1);
    check("idle_ready", in_ready, 0);

    // bytes (first byte in MSBs), bytes sent, write?, data, done, error
    vt[0] = '{48'h0000_02AB_CD64, 6, 1'b1, 18'h2ABCD, 1'b1, 1'b0};
    vt[1] = '{48'h0000_02AB_CD65, 6, 1'b1, 18'h2ABCD, 1'b0, 1'b1};
    vt[2] = '{48'h0000_06AB_CD64, 3, 1'b0, 18'h00000, 1'b0, 1'b1};
    vt[3] = '{48'h0400_02AB_CD64, 1, 1'b0, 18'h00000, 1'b0, 1'b1};
    vt[4] = '{48'h0000_0000_0000, 6, 1'b1, 18'h00000, 1'b1, 1'b0};
    vt[5] = '{48'h0000_03FF_FF03, 6, 1'b1, 18'h3FFFF, 1'b1, 1'b0};
    vt[6] = '{48'h0000_0112_3427, 6, 1'b1, 18'h11234, 1'b1, 1'b0};

    for (int i = 0; i < 7; i++) begin
      pulse_start();
      check($sformatf("vec%0d_start_hold", i), cpu_hold, 1);
      check($sformatf("vec%0d_start_done", i), done, 0);
      check($sformatf("vec%0d_start_err", i), error, 0);
      check($sformatf("vec%0d_start_ready", i), in_ready, 1);
      if (vt[i].we) exp_q.push_back({10'd0, vt[i].data});
      for (int k = 0; k < vt[i].nb; k++) begin
        sh = vt[i].bytes >> (8 * (5 - k));
        send_byte(sh[7:0], 0);
      end
      check($sformatf("vec%0d_done", i), done, vt[i].dn);
      check($sformatf("vec%0d_error", i), error, vt[i].er);
      check($sformatf("vec%0d_hold", i), cpu_hold, !vt[i].dn);
      check($sformatf("vec%0d_ready", i), in_ready, 0);
      check($sformatf("vec%0d_pending_writes", i), exp_q.size(), 0);
      exp_q.delete();
    end

    // Single word latency: HDR_HI cycle counted as 1, done is high in cycle 8.
    pulse_start();
    exp_q.push_back({10'd0, 18'h2ABCD});
    send_byte(8'h00, 0);
    t0 = cyc;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    check("we_after_b2", imem_we, 1);
    send_byte(8'h64, 0);
    check("done_latency", cyc - t0, 6);
    check("lat_done", done, 1);
    check("lat_hold", cpu_hold, 0);

    // Timeout: in_valid drops after HDR_LO, error exactly TMO cycles later.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    n = 0;
    while (!error && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_hold", cpu_hold, 1);
    check("timeout_done", done, 0);

    // Gaps of TMO-1 stall cycles survive; the WRITE cycle before CHK is not counted.
    pulse_start();
    exp_q.push_back({10'd0, 18'h11234});
    send_byte(8'h00, 0);
    send_byte(8'h00, TMO - 1);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h27, TMO);
    check("edge_gap_done", done, 1);
    check("edge_gap_error", error, 0);

    // Backpressure: random gaps, then the same image back-to-back.
    for (int i = 0; i < 10; i++) img[i] = 18'($urandom_range(18'h3FFFF, 0));
    pulse_start();
    send_frame(10, 6, -1, 10);
    check("bp_done", done, 1);
    check("bp_pending", exp_q.size(), 0);
    pulse_start();
    send_frame(10, 0, -1, 10);
    check("b2b_done", done, 1);
    check("b2b_pending", exp_q.size(), 0);

    // Reset mid-load, then a reload with a stray start pulse inside it.
    for (int i = 0; i < 10; i++) img[i] = 18'($urandom_range(18'h3FFFF, 0));
    pulse_start();
    send_frame(10, 2, -1, 4);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_pending", exp_q.size(), 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("midrst_idle_ready", in_ready, 0);
    pulse_start();
    send_frame(10, 2, 4, 10);
    check("reload_done", done, 1);
    check("reload_error", error, 0);
    check("reload_hold", cpu_hold, 0);
    check("reload_pending", exp_q.size(), 0);

    // Full image: count field 1023, word i = i.
    for (int i = 0; i < 1024; i++) img[i] = 18'(i);
    w0 = nwrites;
    pulse_start();
    send_frame(1024, 0, -1, 1024);
    check("full_done", done, 1);
    check("full_writes", nwrites - w0, 1024);
    repeat (5) tick();
    check("full_no_extra", nwrites - w0, 1024);
    check("full_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
